// File: rtl/dmux_rr_sched.sv
// dmux_rr_sched
//   Round-robin burst scheduler in front of a 1-to-4 demultiplexer. One
//   valid/ready source stream is granted to one destination at a time for a
//   burst of BURST beats. The grant index is registered into sel0/sel1 so the
//   demux steering stays constant for the whole burst.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   dst_en      [3:0] destination enable mask
//   in_valid    source beat available
//   in_data     [WIDTH-1:0] source beat
//   in_ready    beat accepted this cycle
//   dst_ready   [3:0] per-destination ready
//   dst_valid   [3:0] one-hot beat valid toward the granted destination
//   dst_data    [WIDTH-1:0] passthrough of in_data
//   sel0, sel1  registered grant index {sel0, sel1}
//   busy        high while a burst is in progress
//   burst_done  pulse on the final beat of a burst or on an abort
module dmux_rr_sched #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       dst_en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [3:0]       dst_ready,
    output logic [3:0]       dst_valid,
    output logic [WIDTH-1:0] dst_data,
    output logic             sel0,
    output logic             sel1,
    output logic             busy,
    output logic             burst_done
);

    localparam int unsigned    CW       = $clog2(BURST + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(BURST - 1);

    typedef enum logic {
        S_IDLE,
        S_XFER
    } state_t;

    state_t        r_state;
    state_t        w_nstate;
    logic [1:0]    r_sel;
    logic [1:0]    r_ptr;
    logic [CW-1:0] r_cnt;

    logic          w_arb_found;
    logic [1:0]    w_arb_idx;
    logic          w_grant;
    logic          w_xfer;
    logic          w_last;
    logic          w_abort;

    // First enabled destination scanning ptr, ptr+1, ... (mod 4).
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = r_ptr;
        for (int unsigned k = 0; k < 4; k++) begin
            if (!w_arb_found && dst_en[2'(r_ptr + 2'(k))]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = 2'(r_ptr + 2'(k));
            end
        end
    end

    // Next state and combinational handshake outputs.
    always_comb begin
        w_nstate   = r_state;
        w_grant    = 1'b0;
        w_xfer     = 1'b0;
        w_last     = 1'b0;
        w_abort    = 1'b0;
        dst_valid  = '0;
        in_ready   = 1'b0;
        burst_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && w_arb_found) begin
                    w_grant  = 1'b1;
                    w_nstate = S_XFER;
                end
            end
            S_XFER: begin
                if (!dst_en[r_sel]) begin
                    // Granted destination disabled: drop the rest of the burst.
                    w_abort = 1'b1;
                end else begin
                    dst_valid[r_sel] = in_valid;
                    in_ready         = dst_ready[r_sel];
                    w_xfer           = in_valid & dst_ready[r_sel];
                    w_last           = w_xfer && (r_cnt == LAST_CNT);
                end
                burst_done = w_last | w_abort;
                if (burst_done) begin
                    w_nstate = S_IDLE;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nstate;
            if (w_grant) begin
                r_sel <= w_arb_idx;
                r_cnt <= '0;
            end else if (w_xfer) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (burst_done) begin
                r_ptr <= r_sel + 2'd1;
            end
        end
    end

    assign dst_data = in_data;
    assign sel0     = r_sel[1];
    assign sel1     = r_sel[0];
    assign busy     = (r_state == S_XFER);

endmodule

// File: tb/tb_dmux_rr_sched.sv
module tb_dmux_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n;

    // BURST = 4 instance
    logic [3:0] dst_en, dst_ready, dst_valid;
    logic       in_valid, in_ready, sel0, sel1, busy, burst_done;
    logic [7:0] in_data, dst_data;

    // BURST = 1 instance
    logic [3:0] b1_en, b1_rdy, b1_dv;
    logic       b1_vld, b1_ir, b1_s0, b1_s1, b1_busy, b1_done;
    logic [7:0] b1_data, b1_dout;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmux_rr_sched #(.WIDTH(8), .BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .dst_en(dst_en), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .dst_ready(dst_ready),
        .dst_valid(dst_valid), .dst_data(dst_data), .sel0(sel0), .sel1(sel1),
        .busy(busy), .burst_done(burst_done)
    );

    dmux_rr_sched #(.WIDTH(8), .BURST(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .dst_en(b1_en), .in_valid(b1_vld),
        .in_data(b1_data), .in_ready(b1_ir), .dst_ready(b1_rdy),
        .dst_valid(b1_dv), .dst_data(b1_dout), .sel0(b1_s0), .sel1(b1_s1),
        .busy(b1_busy), .burst_done(b1_done)
    );

    typedef struct {
        logic [3:0] en;
        logic       vld;
        logic [7:0] data;
        logic [3:0] rdy;
        logic [3:0] e_dv;
        logic       e_ir;
        logic [1:0] e_sel;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] en, input logic vld, input logic [7:0] data,
                       input logic [3:0] rdy, input logic [3:0] dv, input logic ir,
                       input logic [1:0] sel, input logic bsy, input logic done);
        vec_t v;
        v.en = en; v.vld = vld; v.data = data; v.rdy = rdy;
        v.e_dv = dv; v.e_ir = ir; v.e_sel = sel; v.e_busy = bsy; v.e_done = done;
        vq.push_back(v);
    endtask

    task automatic build();
        logic [1:0] g, prev;
        // Full rotation, all enabled: idle arbitration cycle then 4 beats each.
        for (int gi = 0; gi < 4; gi++) begin
            g    = 2'(gi);
            prev = (gi == 0) ? 2'd0 : 2'(gi - 1);
            add(4'hF, 1, 8'(gi * 4), 4'hF, 4'h0, 0, prev, 0, 0);
            for (int j = 0; j < 4; j++)
                add(4'hF, 1, 8'(gi * 4 + j), 4'hF, 4'(1 << gi), 1, g, 1, (j == 3));
        end
        // Masked skip: dst_en = 0101 gives 0,2,0,2 (pointer starts at 0).
        for (int k = 0; k < 4; k++) begin
            g    = 2'((k % 2) * 2);
            prev = (k == 0) ? 2'd3 : 2'(((k - 1) % 2) * 2);
            add(4'h5, 1, 8'(8'h10 + k * 4), 4'hF, 4'h0, 0, prev, 0, 0);
            for (int j = 0; j < 4; j++)
                add(4'h5, 1, 8'(8'h10 + k * 4 + j), 4'hF, 4'(1 << g), 1, g, 1, (j == 3));
        end
        // Nothing enabled: remain idle, sel holds 2.
        for (int k = 0; k < 3; k++) add(4'h0, 1, 8'h18, 4'hF, 4'h0, 0, 2'd2, 0, 0);
        // Backpressure on g=1 (ptr=3, only dst 1 enabled); other ready bits ignored.
        add(4'h2, 1, 8'h20, 4'hF, 4'h0, 0, 2'd2, 0, 0);
        add(4'h2, 1, 8'h20, 4'hF, 4'h2, 1, 2'd1, 1, 0);
        add(4'h2, 1, 8'h21, 4'hF, 4'h2, 1, 2'd1, 1, 0);
        for (int k = 0; k < 3; k++) add(4'h2, 1, 8'h22, 4'hD, 4'h2, 0, 2'd1, 1, 0);
        add(4'h2, 1, 8'h22, 4'hF, 4'h2, 1, 2'd1, 1, 0);
        add(4'h2, 1, 8'h23, 4'hF, 4'h2, 1, 2'd1, 1, 1);
        // Abort: ptr=2, grant 2, one beat, then dst_en[2] drops.
        add(4'hF, 1, 8'h30, 4'hF, 4'h0, 0, 2'd1, 0, 0);
        add(4'hF, 1, 8'h30, 4'hF, 4'h4, 1, 2'd2, 1, 0);
        add(4'hB, 1, 8'h31, 4'hF, 4'h0, 0, 2'd2, 1, 1);
        add(4'hF, 1, 8'h31, 4'hF, 4'h0, 0, 2'd2, 0, 0);
        add(4'hF, 1, 8'h31, 4'hF, 4'h8, 1, 2'd3, 1, 0);
        add(4'hF, 1, 8'h32, 4'hF, 4'h8, 1, 2'd3, 1, 0);
    endtask

    initial begin
        int xfers;
        rst_n = 1'b0;
        dst_en = '0; dst_ready = '0; in_valid = 1'b0; in_data = '0;
        b1_en = '0; b1_rdy = '0; b1_vld = 1'b0; b1_data = '0;
        build();

        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_sel", {sel0, sel1}, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_dvalid", dst_valid, 0);
        chk("rst_done", burst_done, 0);
        chk("b1_rst_busy", b1_busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // BURST = 1: strict per-beat round robin, one beat every 2 cycles.
        b1_en = 4'hF; b1_rdy = 4'hF; b1_vld = 1'b1;
        xfers = 0;
        for (int c = 0; c < 10; c++) begin
            logic [1:0] es;
            b1_data = 8'(c);
            @(negedge clk);
            if (c % 2 == 1) es = 2'((c / 2) % 4);
            else            es = (c == 0) ? 2'd0 : 2'(((c / 2) - 1) % 4);
            chk($sformatf("b1_busy[%0d]", c), b1_busy, 32'(c % 2));
            chk($sformatf("b1_sel[%0d]", c), {b1_s0, b1_s1}, es);
            chk($sformatf("b1_dv[%0d]", c), b1_dv, (c % 2 == 1) ? (1 << es) : 0);
            chk($sformatf("b1_done[%0d]", c), b1_done, 32'(c % 2));
            if (b1_vld && b1_ir) xfers++;
            @(posedge clk); #1;
        end
        chk("b1_xfers", xfers, 5);
        b1_vld = 1'b0;

        // Table-driven vectors on the BURST = 4 instance.
        for (int i = 0; i < vq.size(); i++) begin
            dst_en = vq[i].en; in_valid = vq[i].vld; in_data = vq[i].data; dst_ready = vq[i].rdy;
            @(negedge clk);
            chk($sformatf("dvalid[%0d]", i), dst_valid, vq[i].e_dv);
            chk($sformatf("in_ready[%0d]", i), in_ready, vq[i].e_ir);
            chk($sformatf("sel[%0d]", i), {sel0, sel1}, vq[i].e_sel);
            chk($sformatf("busy[%0d]", i), busy, vq[i].e_busy);
            chk($sformatf("done[%0d]", i), burst_done, vq[i].e_done);
            chk($sformatf("ddata[%0d]", i), dst_data, vq[i].data);
            @(posedge clk); #1;
        end

        // Reset mid-burst: g=3 with cnt=2, ptr=3.
        in_data = 8'h33;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sel", {sel0, sel1}, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_dvalid", dst_valid, 0);
        chk("mid_rst_done", burst_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        @(posedge clk); #1;
        chk("post_rst_busy", busy, 1);
        chk("post_rst_sel", {sel0, sel1}, 0);
        chk("post_rst_dvalid", dst_valid, 4'h1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
